decode_stage: RTL and testbench

Instruction decode stage of the 16-bit pipelined core. Drives the register file read addresses from the IF/ID instruction and captures the returned operands. Decodes control and immediates, detects load-use hazards, and loads the ID/EX pipeline register consumed by the execute stage. Also handles branch flush, HLT retirement gating, and a saturating stall counter.

---
 rtl/decode_stage.sv | 174 +++++++++++++++++
 tb/tb_decode_stage.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - ID stage: decode, operand capture, load-use stall, ID/EX register
module decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [15:0]      id_instr,
  input  logic [15:0]      id_pc_plus2,
  input  logic             flush,
  output logic [3:0]       SrcReg1,
  output logic [3:0]       SrcReg2,
  input  logic [15:0]      SrcData1,
  input  logic [15:0]      SrcData2,
  output logic             stall,
  output logic             ex_valid,
  output logic [3:0]       ex_opcode,
  output logic [3:0]       ex_rd,
  output logic [3:0]       ex_src1,
  output logic [3:0]       ex_src2,
  output logic [15:0]      ex_data1,
  output logic [15:0]      ex_data2,
  output logic [15:0]      ex_imm,
  output logic [15:0]      ex_pc_plus2,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_halt,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  logic [3:0]  opcode, rd, rs, rt;
  logic [3:0]  src1, src2;
  logic        use1, use2;
  logic [15:0] imm;
  logic        regWrite, memRead, memWrite, isHalt;
  logic        hz;

  assign opcode = id_instr[15:12];
  assign rd     = id_instr[11:8];
  assign rs     = id_instr[7:4];
  assign rt     = id_instr[3:0];

  // Decode sources, immediate and control; unused sources read R0 and carry no use flag
  always_comb begin
    src1     = 4'd0;
    src2     = 4'd0;
    use1     = 1'b0;
    use2     = 1'b0;
    imm      = 16'd0;
    regWrite = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    isHalt   = 1'b0;
    case (opcode)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: begin
        src1     = rs;
        use1     = 1'b1;
        src2     = rt;
        use2     = 1'b1;
        regWrite = 1'b1;
      end
      4'h4, 4'h5, 4'h6: begin
        src1     = rs;
        use1     = 1'b1;
        imm      = {12'd0, rt};
        regWrite = 1'b1;
      end
      4'h8: begin
        src1     = rs;
        use1     = 1'b1;
        imm      = {{11{rt[3]}}, rt, 1'b0};
        memRead  = 1'b1;
        regWrite = 1'b1;
      end
      4'h9: begin
        // store data register lives in the rd field
        src1     = rs;
        use1     = 1'b1;
        src2     = rd;
        use2     = 1'b1;
        imm      = {{11{rt[3]}}, rt, 1'b0};
        memWrite = 1'b1;
      end
      4'hA, 4'hB: begin
        // LLB/LHB merge a byte into the existing rd value, so rd is read
        src1     = rd;
        use1     = 1'b1;
        imm      = {8'd0, id_instr[7:0]};
        regWrite = 1'b1;
      end
      4'hC: begin
        imm = {{6{id_instr[8]}}, id_instr[8:0], 1'b0};
      end
      4'hD: begin
        src1 = rs;
        use1 = 1'b1;
      end
      4'hE: begin
        regWrite = 1'b1;
      end
      4'hF: begin
        isHalt = 1'b1;
      end
    endcase
  end

  assign SrcReg1 = src1;
  assign SrcReg2 = src2;

  // A load in EX cannot forward to the instruction in ID; R0 writes are discarded so never hazard
  assign hz = ex_valid & ex_mem_read & (ex_rd != 4'd0) & id_valid &
              ((use1 & (src1 == ex_rd)) | (use2 & (src2 == ex_rd)));

  // Flush overrides everything; once halted any valid fetch is held forever
  assign stall = rst & ~flush & (halted ? id_valid : hz);

  // ID/EX pipeline register, halt latch and saturating load-use bubble counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= 4'd0;
      ex_rd        <= 4'd0;
      ex_src1      <= 4'd0;
      ex_src2      <= 4'd0;
      ex_data1     <= 16'd0;
      ex_data2     <= 16'd0;
      ex_imm       <= 16'd0;
      ex_pc_plus2  <= 16'd0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_halt      <= 1'b0;
      halted       <= 1'b0;
      stall_count  <= '0;
    end else if (id_valid && !flush && !halted && !hz) begin
      ex_valid     <= 1'b1;
      ex_opcode    <= opcode;
      ex_rd        <= rd;
      ex_src1      <= src1;
      ex_src2      <= src2;
      ex_data1     <= SrcData1;
      ex_data2     <= SrcData2;
      ex_imm       <= imm;
      ex_pc_plus2  <= id_pc_plus2;
      ex_reg_write <= regWrite & (rd != 4'd0);
      ex_mem_read  <= memRead;
      ex_mem_write <= memWrite;
      ex_halt      <= isHalt;
      if (isHalt) begin
        halted <= 1'b1;
      end
    end else begin
      ex_valid     <= 1'b0;
      ex_opcode    <= 4'd0;
      ex_rd        <= 4'd0;
      ex_src1      <= 4'd0;
      ex_src2      <= 4'd0;
      ex_data1     <= 16'd0;
      ex_data2     <= 16'd0;
      ex_imm       <= 16'd0;
      ex_pc_plus2  <= 16'd0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_halt      <= 1'b0;
      if (!flush && !halted && hz && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic        v;
    logic [3:0]  op, rd, s1, s2;
    logic [15:0] d1, d2, imm, pc;
    logic        rw, mr, mw, hl;
  } ex_t;

  typedef struct packed {
    logic [3:0]  s1, s2;
    logic        u1, u2;
    logic [15:0] imm;
    logic        rw, mr, mw, hl;
  } dec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic id_valid = 1'b0;
  logic [15:0] id_instr = 16'd0;
  logic [15:0] id_pc_plus2 = 16'd0;
  logic flush = 1'b0;
  logic [3:0] SrcReg1, SrcReg2;
  logic [15:0] SrcData1, SrcData2;
  logic stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt, halted;
  logic [3:0] ex_opcode, ex_rd, ex_src1, ex_src2;
  logic [15:0] ex_data1, ex_data2, ex_imm, ex_pc_plus2;
  logic [CNT_W-1:0] stall_count;

  logic [15:0] rf [16];
  assign SrcData1 = rf[SrcReg1];
  assign SrcData2 = rf[SrcReg2];

  ex_t actEx;
  assign actEx = {ex_valid, ex_opcode, ex_rd, ex_src1, ex_src2, ex_data1, ex_data2,
                  ex_imm, ex_pc_plus2, ex_reg_write, ex_mem_read, ex_mem_write, ex_halt};

  always #5 clk = ~clk;

  decode_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_plus2(id_pc_plus2), .flush(flush), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .SrcData1(SrcData1), .SrcData2(SrcData2), .stall(stall), .ex_valid(ex_valid),
    .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_pc_plus2(ex_pc_plus2),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_halt(ex_halt), .halted(halted), .stall_count(stall_count)
  );

  int   checks = 0;
  int   errors = 0;
  ex_t  mEx = '0;
  logic mHalted = 1'b0;
  int   mCount = 0;

  // Instruction semantics from the ISA table, in plain arithmetic
  function automatic dec_t refDecode(input logic [15:0] ins);
    dec_t d;
    int op, v;
    logic [3:0] a, b, c;
    op = int'(ins[15:12]);
    a = ins[11:8];
    b = ins[7:4];
    c = ins[3:0];
    d = '0;
    if (op <= 3 || op == 7) begin
      d.u1 = 1'b1; d.s1 = b; d.u2 = 1'b1; d.s2 = c; d.rw = 1'b1;
    end else if (op <= 6) begin
      d.u1 = 1'b1; d.s1 = b; d.imm = 16'(c); d.rw = 1'b1;
    end else if (op == 8 || op == 9) begin
      v = (int'(c) >= 8) ? int'(c) - 16 : int'(c);
      d.imm = 16'(v * 2);
      d.u1 = 1'b1; d.s1 = b;
      if (op == 8) begin
        d.mr = 1'b1; d.rw = 1'b1;
      end else begin
        d.mw = 1'b1; d.u2 = 1'b1; d.s2 = a;
      end
    end else if (op == 10 || op == 11) begin
      d.u1 = 1'b1; d.s1 = a; d.imm = 16'(int'(ins[7:0])); d.rw = 1'b1;
    end else if (op == 12) begin
      v = int'(ins[8:0]);
      if (v >= 256) v = v - 512;
      d.imm = 16'(v * 2);
    end else if (op == 13) begin
      d.u1 = 1'b1; d.s1 = b;
    end else if (op == 14) begin
      d.rw = 1'b1;
    end else begin
      d.hl = 1'b1;
    end
    return d;
  endfunction

  function automatic logic refHazard();
    dec_t d;
    d = refDecode(id_instr);
    return mEx.v && mEx.mr && (mEx.rd != 0) && id_valid &&
           ((d.u1 && d.s1 == mEx.rd) || (d.u2 && d.s2 == mEx.rd));
  endfunction

  function automatic logic expStall();
    if (!rst || flush) return 1'b0;
    if (mHalted) return id_valid;
    return refHazard();
  endfunction

  task automatic drive(input logic v, input logic [15:0] ins, input logic fl);
    id_valid    = v;
    id_instr    = ins;
    id_pc_plus2 = 16'($urandom);
    flush       = fl;
    #1;
  endtask

  // Advance one clock: model computes its next state from the inputs seen at the edge
  task automatic tick();
    dec_t d;
    ex_t nx;
    logic nh;
    int nc;
    d  = refDecode(id_instr);
    nx = '0;
    nh = mHalted;
    nc = mCount;
    if (!rst) begin
      nh = 1'b0; nc = 0;
    end else if (flush || mHalted) begin
      nx = '0;
    end else if (refHazard()) begin
      if (nc < CMAX) nc = nc + 1;
    end else if (id_valid) begin
      nx.v = 1'b1; nx.op = id_instr[15:12]; nx.rd = id_instr[11:8];
      nx.s1 = d.s1; nx.s2 = d.s2; nx.d1 = rf[d.s1]; nx.d2 = rf[d.s2];
      nx.imm = d.imm; nx.pc = id_pc_plus2;
      nx.rw = d.rw && (id_instr[11:8] != 4'd0);
      nx.mr = d.mr; nx.mw = d.mw; nx.hl = d.hl;
      if (d.hl) nh = 1'b1;
    end
    @(posedge clk);
    #1;
    mEx = nx; mHalted = nh; mCount = nc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0312, 1'b0);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
      tick();
      checks++;
      if (actEx !== '0 || halted !== 1'b0 || stall_count !== '0) begin
        errors++;
        $display("FAIL reset_state ex=%h halted=%0b cnt=%0d exp all zero", actEx, halted, stall_count);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_add();
    rf[1] = 16'h0005; rf[2] = 16'h0007;
    drive(1'b1, 16'h0312, 1'b0);
    checks++;
    if (SrcReg1 !== 4'd1 || SrcReg2 !== 4'd2 || stall !== 1'b0) begin
      errors++;
      $display("FAIL add_srcreg got %0d/%0d stall %0b exp 1/2 stall 0", SrcReg1, SrcReg2, stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 4'd3 || ex_data1 !== 16'h0005 || ex_data2 !== 16'h0007 ||
        ex_reg_write !== 1'b1) begin
      errors++;
      $display("FAIL add_issue v=%0b rd=%0d d1=%h d2=%h rw=%0b exp 1 3 0005 0007 1",
               ex_valid, ex_rd, ex_data1, ex_data2, ex_reg_write);
    end
    checks++;
    if (actEx !== mEx) begin errors++; $display("FAIL add_model got %h exp %h", actEx, mEx); end
    drive(1'b0, 16'h0000, 1'b0);
    tick();
  endtask

  task automatic test_load_use();
    int c0;
    c0 = int'(stall_count);
    drive(1'b1, 16'h8411, 1'b0);
    tick();
    drive(1'b1, 16'h0542, 1'b0);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b exp 1", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || int'(stall_count) != c0 + 1) begin
      errors++;
      $display("FAIL lu_bubble v=%0b cnt=%0d exp 0 %0d", ex_valid, stall_count, c0 + 1);
    end
    drive(1'b1, 16'h0542, 1'b0);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got %0b exp 0", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_src1 !== 4'd4 || actEx !== mEx) begin
      errors++;
      $display("FAIL lu_issue got %h exp %h (src1 4)", actEx, mEx);
    end
  endtask

  task automatic test_no_stall_cases();
    logic [15:0] prod [3];
    logic [15:0] cons [3];
    logic        exp  [3];
    prod = '{16'h8011, 16'h8411, 16'h8411};
    cons = '{16'h0502, 16'h4514, 16'h9410};
    exp  = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, prod[i], 1'b0);
      tick();
      drive(1'b1, cons[i], 1'b0);
      checks++;
      if (stall !== exp[i] || stall !== expStall()) begin
        errors++;
        $display("FAIL case_stall_%0d instr %h got %0b exp %0b", i, cons[i], stall, exp[i]);
      end
      tick();
      if (exp[i]) begin
        drive(1'b1, cons[i], 1'b0);
        tick();
      end
      checks++;
      if (actEx !== mEx) begin errors++; $display("FAIL case_issue_%0d got %h exp %h", i, actEx, mEx); end
    end
  endtask

  task automatic test_flush_hazard();
    logic [CNT_W-1:0] c0;
    drive(1'b1, 16'h8411, 1'b0);
    tick();
    c0 = stall_count;
    drive(1'b1, 16'h0542, 1'b1);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b exp 0", stall); end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || stall_count !== c0) begin
      errors++;
      $display("FAIL flush_bubble v=%0b cnt=%0d exp 0 %0d", ex_valid, stall_count, c0);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(1'b1, 16'h8411, 1'b0);
      tick();
      drive(1'b1, 16'h0542, 1'b0);
      tick();
    end
    checks++;
    if (stall_count !== CNT_W'(CMAX) || int'(stall_count) != mCount) begin
      errors++;
      $display("FAIL sat_count got %0d exp %0d", stall_count, CMAX);
    end
    drive(1'b1, 16'h0542, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 16'h8411, 1'b0);
    tick();
    drive(1'b1, 16'h0542, 1'b0);
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall); end
    tick();
    rst = 1'b1;
    drive(1'b1, 16'h0542, 1'b0);
    checks++;
    if (ex_valid !== 1'b0 || stall !== 1'b0 || stall_count !== '0) begin
      errors++;
      $display("FAIL rst_release v=%0b stall=%0b cnt=%0d exp 0 0 0", ex_valid, stall, stall_count);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic        v, fl, held;
    held = 1'b0;
    ins  = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 16; r++) rf[r] = (r == 0) ? 16'h0000 : 16'($urandom);
      if (!held) begin
        ins = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 5)),
               4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
        v = ($urandom_range(0, 9) != 0);
      end
      fl  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) != 0);
      drive(v, ins, fl);
      checks++;
      if (stall !== expStall() || SrcReg1 !== refDecode(ins).s1 || SrcReg2 !== refDecode(ins).s2) begin
        errors++;
        $display("FAIL rand_comb cyc %0d instr %h stall %0b exp %0b src %0d/%0d",
                 i, ins, stall, expStall(), SrcReg1, SrcReg2);
      end
      held = stall;
      tick();
      checks++;
      if (actEx !== mEx || halted !== mHalted || int'(stall_count) != mCount) begin
        errors++;
        $display("FAIL rand_ex cyc %0d got %h cnt %0d exp %h cnt %0d", i, actEx, stall_count, mEx, mCount);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_halt();
    drive(1'b1, 16'hF000, 1'b0);
    tick();
    checks++;
    if (ex_halt !== 1'b1 || halted !== 1'b1 || ex_valid !== 1'b1 || ex_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL halt_issue halt=%0b halted=%0b v=%0b rw=%0b exp 1 1 1 0", ex_halt, halted, ex_valid, ex_reg_write);
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h0312, 1'b0);
      checks++;
      if (stall !== 1'b1) begin errors++; $display("FAIL halt_stall cyc %0d got %0b exp 1", i, stall); end
      tick();
      checks++;
      if (ex_valid !== 1'b0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_bubble cyc %0d v=%0b halted=%0b exp 0 1", i, ex_valid, halted);
      end
    end
    drive(1'b0, 16'h0312, 1'b0);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL halt_idle got %0b exp 0", stall); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(1'b1, 16'h0312, 1'b0);
    checks++;
    if (halted !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset halted=%0b stall=%0b exp 0 0", halted, stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || actEx !== mEx) begin errors++; $display("FAIL halt_resume got %h exp %h", actEx, mEx); end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rf[r] = 16'(r * 16'h0111);
    test_reset();
    test_add();
    test_load_use();
    test_no_stall_cases();
    test_flush_hazard();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
